// File: rtl/serial_alu_pkg.sv
// Shared opcode encodings and sequencer state type for the bit-serial ALU controller.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_GT  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_alu_bitcnt.sv
// Bit-position counter for the serial sequencer; flags the final bit of an operation.
module serial_alu_bitcnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] count_q;

  assign last_o = (count_q == CNT_W'(WIDTH - 1));

  // Wraps to zero after the last bit so the next operation starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= last_o ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial sequencer feeding an external 1-bit ALU slice, LSB first.
// Optional zero_o result flag is built when SERIAL_ALU_ZERO_FLAG_EN is defined.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_c_o,
  output logic [1:0]       slice_aluctr_o,
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  output logic             zero_o,
`endif
  input  logic             slice_d_i,
  input  logic             slice_e_i
);

  state_e           state_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [1:0]       op_q;
  logic             carry_q;
  logic             accept;
  logic             cnt_en;
  logic             cnt_last;

  assign accept   = (state_q == IDLE) && start_i && ready_o;
  assign cnt_en   = (state_q == RUN);
  assign res_next = {slice_d_i, res_sh[WIDTH-1:1]};

  // Operand shifters zero-fill, so their LSBs read 0 once all bits are consumed.
  assign slice_a_o      = a_sh[0];
  assign slice_b_o      = b_sh[0];
  assign slice_c_o      = carry_q;
  assign slice_aluctr_o = op_q;

  serial_alu_bitcnt #(
    .WIDTH (WIDTH)
  ) u_bitcnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (cnt_en),
    .last_o (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_o  <= 1'b1;
      done_o   <= 1'b0;
      result_o <= '0;
      flag_o   <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op_q     <= 2'b00;
      carry_q  <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
      zero_o   <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            ready_o <= 1'b0;
            a_sh    <= a_i;
            b_sh    <= b_i;
            op_q    <= op_i;
            carry_q <= 1'b0;
            res_sh  <= '0;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next;
          // Final chain bit goes straight to flag_o; the slice carry returns to 0 outside RUN.
          if (cnt_last) begin
            state_q  <= DONE;
            done_o   <= 1'b1;
            result_o <= res_next;
            flag_o   <= slice_e_i;
            carry_q  <= 1'b0;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
            zero_o   <= (res_next == '0);
`endif
          end else begin
            carry_q <= slice_e_i;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Self-checking bench for serial_alu_ctrl with a behavioural 1-bit slice attached.
module tb_serial_alu_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         ready_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         flag_o;
  logic         slice_a_o;
  logic         slice_b_o;
  logic         slice_c_o;
  logic [1:0]   slice_aluctr_o;
  logic         slice_d_i;
  logic         slice_e_i;
`ifdef SERIAL_ALU_ZERO_FLAG_EN
  logic         zero_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .op_i           (op_i),
    .a_i            (a_i),
    .b_i            (b_i),
    .ready_o        (ready_o),
    .done_o         (done_o),
    .result_o       (result_o),
    .flag_o         (flag_o),
    .slice_a_o      (slice_a_o),
    .slice_b_o      (slice_b_o),
    .slice_c_o      (slice_c_o),
    .slice_aluctr_o (slice_aluctr_o),
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    .zero_o         (zero_o),
`endif
    .slice_d_i      (slice_d_i),
    .slice_e_i      (slice_e_i)
  );

  // The combinational 1-bit ALU slice the controller drives.
  always_comb begin
    slice_d_i = 1'b0;
    slice_e_i = 1'b0;
    case (slice_aluctr_o)
      2'b00: begin
        slice_d_i = slice_a_o ^ slice_b_o ^ slice_c_o;
        slice_e_i = (slice_a_o & slice_b_o) | (slice_c_o & (slice_a_o ^ slice_b_o));
      end
      2'b01: slice_d_i = slice_a_o & slice_b_o;
      2'b10: slice_e_i = (slice_a_o & ~slice_b_o) | (~(slice_a_o ^ slice_b_o) & slice_c_o);
      default: slice_d_i = slice_a_o ^ slice_b_o;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: what the whole serial operation must produce.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic f);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    r = '0;
    f = 1'b0;
    case (op)
      2'b00: begin r = s[W-1:0]; f = s[W]; end
      2'b01: r = a & b;
      2'b10: f = (a > b);
      default: r = a ^ b;
    endcase
  endfunction

  // Issues one op; optional stray start during RUN and/or in the done_o cycle.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inject, input bit start_at_done);
    logic [W-1:0] er;
    logic         ef;
    int           n;
    bit           got;
    model(op, a, b, er, ef);
    check("ready_before_start", 32'(ready_o), 32'd1);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (done_o) begin
        got = 1'b1;
      end else begin
        if (n < int'(W)) begin
          check("run_slice_a", 32'(slice_a_o), 32'(a[n]));
          check("run_slice_b", 32'(slice_b_o), 32'(b[n]));
          check("run_aluctr", 32'(slice_aluctr_o), 32'(op));
          check("run_ready_low", 32'(ready_o), 32'd0);
        end
        if (n == inject) begin
          start_i = 1'b1; a_i = 8'hAA; b_i = 8'hAA; op_i = 2'b11;
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        n++;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    // Accept edge plus WIDTH RUN cycles: done_o is visible WIDTH edges after acceptance.
    check("done_latency", 32'(n), 32'(W));
    check("result", 32'(result_o), 32'(er));
    check("flag", 32'(ef), 32'(flag_o) ^ 32'(ef) ^ 32'(ef));
    check("ready_in_done", 32'(ready_o), 32'd0);
    check("slice_c_in_done", 32'(slice_c_o), 32'd0);
`ifdef SERIAL_ALU_ZERO_FLAG_EN
    check("zero", 32'(zero_o), 32'(er == '0));
`endif
    if (start_at_done) start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("done_pulse_end", 32'(done_o), 32'd0);
    check("ready_after", 32'(ready_o), 32'd1);
    check("idle_slice_ab", 32'({slice_a_o, slice_b_o}), 32'd0);
    check("idle_aluctr", 32'(slice_aluctr_o), 32'(op));
    check("result_held", 32'(result_o), 32'(er));
  endtask

  initial begin
    int extra;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_flag", 32'(flag_o), 32'd0);
    check("rst_slice", 32'({slice_a_o, slice_b_o, slice_c_o, slice_aluctr_o}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 8'hFF, 8'h01, -1, 1'b0);
    run_op(2'b00, 8'h3C, 8'h05, -1, 1'b0);
    run_op(2'b01, 8'hF0, 8'h3C, -1, 1'b0);
    run_op(2'b11, 8'hF0, 8'h3C, -1, 1'b0);
    run_op(2'b10, 8'h80, 8'h7F, -1, 1'b0);
    run_op(2'b10, 8'h55, 8'h55, -1, 1'b0);
    run_op(2'b10, 8'h01, 8'h02, -1, 1'b0);

    // Stray starts during RUN and in the done_o cycle must both be dropped.
    run_op(2'b00, 8'h01, 8'h01, 3, 1'b1);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_o) extra++;
      if (!ready_o) extra++;
    end
    check("stray_start_ignored", 32'(extra), 32'd0);

    // Reset four cycles into RUN.
    start_i = 1'b1; op_i = 2'b00; a_i = 8'h77; b_i = 8'h11;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_result", 32'(result_o), 32'd0);
    check("midrst_flag", 32'(flag_o), 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done_o) extra++;
    end
    check("midrst_no_done", 32'(extra), 32'd0);
    run_op(2'b00, 8'h10, 8'h20, -1, 1'b0);

`ifdef SERIAL_ALU_ZERO_FLAG_EN
    run_op(2'b11, 8'h5A, 8'h5A, -1, 1'b0);
    run_op(2'b00, 8'h01, 8'h00, -1, 1'b0);
`endif

    // Boundary operands, then random traffic.
    run_op(2'b10, 8'hFF, 8'hFE, -1, 1'b0);
    run_op(2'b10, 8'h7F, 8'h80, -1, 1'b0);
    run_op(2'b00, 8'hFF, 8'hFF, -1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = (i % 5 == 0) ? ra : W'($urandom);
      run_op(2'($urandom_range(0, 3)), ra, rb, -1, 1'(i % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
